hybrid_branch_predictor: RTL and testbench
==========================================

// Module: hybrid_branch_predictor
// PURPOSE
// - Parametrised tournament predictor for the Chronos fetch stage: bimodal PHT, gshare PHT, per-PC chooser, direct-mapped BTB.
// - Combinational lookup on the fetch PC. Returns direction and target in the same cycle for the PC mux.
// - Resolved branches from EX update all tables on the next clock edge.
// - Successor to the fixed-size branch_predictor: adds configurable table depth, history length and target width, plus a misprediction counter.
// PARAMETERS
// XLEN          32  address/target width
// PHT_IDX_BITS  8   log2 entries of bimodal PHT, gshare PHT and chooser (each 2^PHT_IDX_BITS x 2b)
// GHR_BITS      8   global history length; legal range 1..PHT_IDX_BITS
// BTB_IDX_BITS  6   log2 BTB entries; tag = pc[XLEN-1:BTB_IDX_BITS+2]
// PORTS
// clk              in   1     rising-edge clock
// rst              in   1     asynchronous reset, active-low
// lookup_pc        in   XLEN  current fetch PC
// pred_taken       out  1     predict taken (BTB hit AND selected counter >= 2)
// pred_target      out  XLEN  BTB target if pred_taken, else lookup_pc+4
// pred_btb_hit     out  1     BTB valid && tag match for lookup_pc
// upd_valid        in   1     one resolved conditional branch this cycle
// upd_pc           in   XLEN  PC of resolved branch
// upd_taken        in   1     actual outcome
// upd_target       in   XLEN  actual taken target
// upd_mispredict   in   1     EX detected direction or target mispredict
// ghr_out          out  GHR_BITS  committed global history (debug)
// stat_mispredicts out  32    saturating count of upd_valid&&upd_mispredict
// BEHAVIOUR
// - Index mapping:
//   - bi_idx = pc[PHT_IDX_BITS+1:2]; gs_idx = bi_idx ^ {zero-extended GHR}; ch_idx = bi_idx.
//   - btb_idx = pc[BTB_IDX_BITS+1:2].
// - Lookup is purely combinational from lookup_pc and current state: zero-cycle latency. No bypass.
//   - A lookup in the same cycle as an update to the same entry sees the pre-update value.
// - Selection: chooser >= 2 selects the gshare counter, else the bimodal counter.
// - Counters are 2-bit saturating: 0/1 = not taken, 2/3 = taken. Taken increments, stops at 3; not-taken decrements, stops at 0.
// - Update, on a clock edge with upd_valid=1:
//   - All indices use upd_pc and the GHR value BEFORE this edge's shift.
//   - Bimodal and gshare counters both train toward upd_taken.
//   - Chooser trains only when the components' predictions disagree:
//     - +1 if gshare was correct, -1 if bimodal was correct.
//     - Component predictions are recomputed from pre-edge counter values.
//   - GHR <= {GHR[GHR_BITS-2:0], upd_taken}; GHR_BITS=1 yields GHR <= upd_taken. The GHR is committed, non-speculative.
//   - upd_taken=1: BTB[btb_idx] <= {valid=1, tag, upd_target}. This overwrites any prior entry (no replacement policy).
//   - upd_taken=0: BTB entry is untouched.
//   - upd_mispredict=1: stat_mispredicts increments, holding at 32'hFFFF_FFFF.
// - upd_valid=0: no state changes. upd_mispredict is ignored.
// - Reset (rst=0, asynchronous, any cycle including mid-update): all of the following take effect immediately and the in-flight update is discarded.
//   - All PHT counters = 2'b01 (weakly not taken).
//   - All chooser entries = 2'b01 (weakly bimodal).
//   - GHR = 0; all BTB valid bits = 0; stat_mispredicts = 0.
//   - Outputs follow: pred_taken=0, pred_btb_hit=0, pred_target=lookup_pc+4, ghr_out=0.
// - pc+4 wraps modulo 2^XLEN (e.g. 32'hFFFF_FFFC -> 32'h0000_0000).
// - pc[1:0] is ignored everywhere; a BTB tag mismatch forces pred_taken=0 regardless of counters.
// TESTING
// - Reset, then lookup_pc=0x100 -> pred_taken=0, pred_btb_hit=0, pred_target=0x104, ghr_out=0, stat=0.
// - Two updates at pc=0x100 (taken, target=0x40), then lookup 0x100:
//   - Response: pred_btb_hit=1, pred_taken=1, pred_target=0x40, ghr_out=8'b11.
//   - One further not-taken update: bimodal returns to 2, still predicts taken.
// - BTB alias: taken update at 0x100 (target 0x40), then taken update at 0x100+(4<<BTB_IDX_BITS)=0x200 (target 0x80):
//   - Lookup 0x100 -> pred_btb_hit=0, pred_taken=0.
//   - Lookup 0x200 -> target 0x80.
// - Alternating T/N/T/N pattern at pc=0x300 for 40 updates, final outcome taken:
//   - Chooser saturates to 3; prediction at 0x300 matches gshare; ghr_out=8'b01010101 (newest outcome in bit 0).
// - Update with upd_mispredict=1 and stat forced near max via 2^32-1 events (or force): counter holds at 32'hFFFF_FFFF.
// - Same-cycle lookup and update at 0x100: pred_taken shows the old value that cycle and the new value the next cycle.
// - rst asserted mid-update: the update is discarded and all reset values hold while rst=0.

Source files
------------

// File: rtl/hybrid_branch_predictor.sv
// Tournament branch predictor: bimodal + gshare PHTs, a per-PC chooser and a direct-mapped BTB.
// Lookup is combinational on the fetch PC; resolved branches train every table on the next clock edge.
module hybrid_branch_predictor #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PHT_IDX_BITS = 8,
  parameter int unsigned GHR_BITS     = 8,
  parameter int unsigned BTB_IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     lookup_pc,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_target,
  output logic                pred_btb_hit,
  input  logic                upd_valid,
  input  logic [XLEN-1:0]     upd_pc,
  input  logic                upd_taken,
  input  logic [XLEN-1:0]     upd_target,
  input  logic                upd_mispredict,
  output logic [GHR_BITS-1:0] ghr_out,
  output logic [31:0]         stat_mispredicts
);

  localparam int unsigned PHT_N  = 1 << PHT_IDX_BITS;
  localparam int unsigned BTB_N  = 1 << BTB_IDX_BITS;
  localparam int unsigned TAG_W  = XLEN - BTB_IDX_BITS - 2;
  localparam int unsigned STAT_W = 32;

  logic [1:0]              r_bi [PHT_N];
  logic [1:0]              r_gs [PHT_N];
  logic [1:0]              r_ch [PHT_N];
  logic [GHR_BITS-1:0]     r_ghr;
  logic [BTB_N-1:0]        r_btb_valid;
  logic [TAG_W-1:0]        r_btb_tag    [BTB_N];
  logic [XLEN-1:0]         r_btb_target [BTB_N];
  logic [STAT_W-1:0]       r_stat;

  logic [PHT_IDX_BITS-1:0] w_ghr_ext;
  logic [PHT_IDX_BITS-1:0] w_lk_bi_idx;
  logic [PHT_IDX_BITS-1:0] w_lk_gs_idx;
  logic [BTB_IDX_BITS-1:0] w_lk_btb_idx;
  logic [TAG_W-1:0]        w_lk_tag;
  logic [1:0]              w_lk_sel_cnt;
  logic                    w_lk_hit;

  logic [PHT_IDX_BITS-1:0] w_up_bi_idx;
  logic [PHT_IDX_BITS-1:0] w_up_gs_idx;
  logic [BTB_IDX_BITS-1:0] w_up_btb_idx;
  logic [TAG_W-1:0]        w_up_tag;
  logic [1:0]              w_up_bi_cnt;
  logic [1:0]              w_up_gs_cnt;
  logic                    w_bi_pred;
  logic                    w_gs_pred;
  logic [GHR_BITS-1:0]     w_ghr_next;
  logic                    w_unused_pc_lsbs;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
    return (cnt == 2'd0) ? cnt : cnt - 2'd1;
  endfunction

  assign w_ghr_ext = PHT_IDX_BITS'(r_ghr);

  // Lookup path: same-cycle updates are not bypassed, so this always sees pre-edge state.
  assign w_lk_bi_idx  = lookup_pc[PHT_IDX_BITS+1:2];
  assign w_lk_gs_idx  = w_lk_bi_idx ^ w_ghr_ext;
  assign w_lk_btb_idx = lookup_pc[BTB_IDX_BITS+1:2];
  assign w_lk_tag     = lookup_pc[XLEN-1:BTB_IDX_BITS+2];
  assign w_lk_sel_cnt = r_ch[w_lk_bi_idx][1] ? r_gs[w_lk_gs_idx] : r_bi[w_lk_bi_idx];
  assign w_lk_hit     = r_btb_valid[w_lk_btb_idx] && (r_btb_tag[w_lk_btb_idx] == w_lk_tag);

  assign pred_btb_hit     = w_lk_hit;
  assign pred_taken       = w_lk_hit && w_lk_sel_cnt[1];
  assign pred_target      = pred_taken ? r_btb_target[w_lk_btb_idx] : lookup_pc + XLEN'(4);
  assign ghr_out          = r_ghr;
  assign stat_mispredicts = r_stat;

  // Update path indices and component predictions, all from pre-edge state.
  assign w_up_bi_idx      = upd_pc[PHT_IDX_BITS+1:2];
  assign w_up_gs_idx      = w_up_bi_idx ^ w_ghr_ext;
  assign w_up_btb_idx     = upd_pc[BTB_IDX_BITS+1:2];
  assign w_up_tag         = upd_pc[XLEN-1:BTB_IDX_BITS+2];
  assign w_up_bi_cnt      = r_bi[w_up_bi_idx];
  assign w_up_gs_cnt      = r_gs[w_up_gs_idx];
  assign w_bi_pred        = w_up_bi_cnt[1];
  assign w_gs_pred        = w_up_gs_cnt[1];
  assign w_ghr_next       = GHR_BITS'({r_ghr, upd_taken});
  assign w_unused_pc_lsbs = ^upd_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(PHT_N); i++) begin
        r_bi[i] <= 2'b01;
        r_gs[i] <= 2'b01;
        r_ch[i] <= 2'b01;
      end
      r_ghr       <= '0;
      r_btb_valid <= '0;
      r_stat      <= '0;
    end else if (upd_valid) begin
      r_bi[w_up_bi_idx] <= sat_step(w_up_bi_cnt, upd_taken);
      r_gs[w_up_gs_idx] <= sat_step(w_up_gs_cnt, upd_taken);
      if (w_bi_pred != w_gs_pred) begin
        r_ch[w_up_bi_idx] <= sat_step(r_ch[w_up_bi_idx], w_gs_pred == upd_taken);
      end
      r_ghr <= w_ghr_next;
      if (upd_taken) begin
        r_btb_valid[w_up_btb_idx] <= 1'b1;
      end
      if (upd_mispredict && (r_stat != '1)) begin
        r_stat <= r_stat + STAT_W'(1);
      end
    end
  end

  // Tag/target payload needs no reset: it is only visible behind a valid bit.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      r_btb_tag[w_up_btb_idx]    <= w_up_tag;
      r_btb_target[w_up_btb_idx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_hybrid_branch_predictor.sv
// Randomised bench for hybrid_branch_predictor against a table-level behavioural model,
// plus directed scenarios for BTB aliasing, history, saturation and asynchronous reset.
module tb_hybrid_branch_predictor;

  localparam int unsigned PHT_N = 256;
  localparam int unsigned BTB_N = 64;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_btb_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [7:0]  ghr_out;
  logic [31:0] stat_mispredicts;

  int n_checks;
  int n_errors;

  hybrid_branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .pred_btb_hit     (pred_btb_hit),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .ghr_out          (ghr_out),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: counters as plain integers clamped to 0..3.
  int          m_bi [PHT_N];
  int          m_gs [PHT_N];
  int          m_ch [PHT_N];
  int unsigned m_ghr;
  bit          m_bv   [BTB_N];
  int unsigned m_btag [BTB_N];
  logic [31:0] m_btgt [BTB_N];
  logic [31:0] m_stat;

  bit          p_valid;
  logic [31:0] p_pc;
  logic        p_taken;
  logic [31:0] p_target;
  logic        p_mis;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 3) return 3;
    if (v < 0) return 0;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(PHT_N); i++) begin
      m_bi[i] = 1;
      m_gs[i] = 1;
      m_ch[i] = 1;
    end
    for (int i = 0; i < int'(BTB_N); i++) m_bv[i] = 1'b0;
    m_ghr  = 0;
    m_stat = 32'd0;
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output logic t,
                                        output logic [31:0] tg, output logic h);
    int unsigned bi_i, gs_i, b_i, tag;
    int sel;
    bi_i = (pc / 4) % PHT_N;
    gs_i = bi_i ^ m_ghr;
    b_i  = (pc / 4) % BTB_N;
    tag  = pc / (4 * BTB_N);
    sel  = (m_ch[bi_i] >= 2) ? m_gs[gs_i] : m_bi[bi_i];
    h    = m_bv[b_i] && (m_btag[b_i] == tag);
    t    = h && (sel >= 2);
    tg   = t ? m_btgt[b_i] : pc + 32'd4;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic t,
                                       input logic [31:0] tgt, input logic mis);
    int unsigned bi_i, gs_i, b_i;
    bit bp, gp;
    int dir;
    bi_i = (pc / 4) % PHT_N;
    gs_i = bi_i ^ m_ghr;
    b_i  = (pc / 4) % BTB_N;
    bp   = m_bi[bi_i] >= 2;
    gp   = m_gs[gs_i] >= 2;
    dir  = t ? 1 : -1;
    if (bp != gp) m_ch[bi_i] = clamp(m_ch[bi_i] + ((gp == t) ? 1 : -1));
    m_bi[bi_i] = clamp(m_bi[bi_i] + dir);
    m_gs[gs_i] = clamp(m_gs[gs_i] + dir);
    m_ghr = ((m_ghr * 2) + (t ? 1 : 0)) % 256;
    if (t) begin
      m_bv[b_i]   = 1'b1;
      m_btag[b_i] = pc / (4 * BTB_N);
      m_btgt[b_i] = tgt;
    end
    if (mis && (m_stat != 32'hFFFF_FFFF)) m_stat = m_stat + 32'd1;
  endfunction

  // One cycle: retire the previous cycle's update into the model, drive, then compare pre-edge outputs.
  task automatic step(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic um);
    logic et, eh;
    logic [31:0] etg;
    @(negedge clk);
    if (p_valid) model_update(p_pc, p_taken, p_target, p_mis);
    lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_mispredict = um;
    p_valid = uv; p_pc = upc; p_taken = ut; p_target = utgt; p_mis = um;
    #1;
    model_predict(lpc, et, etg, eh);
    check_eq("pred_taken",   64'(pred_taken),       64'(et));
    check_eq("pred_btb_hit", 64'(pred_btb_hit),     64'(eh));
    check_eq("pred_target",  64'(pred_target),      64'(etg));
    check_eq("ghr_out",      64'(ghr_out),          64'(m_ghr));
    check_eq("stat",         64'(stat_mispredicts), 64'(m_stat));
  endtask

  task automatic look(input logic [31:0] lpc);
    step(lpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    pc = 32'h100 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 3)) << 8);
    return pc | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    n_checks = 0; n_errors = 0;
    p_valid = 1'b0; p_pc = '0; p_taken = 1'b0; p_target = '0; p_mis = 1'b0;
    rst = 1'b0; lookup_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    model_reset();

    #12;
    check_eq("rst_pred_taken",  64'(pred_taken),       64'd0);
    check_eq("rst_btb_hit",     64'(pred_btb_hit),     64'd0);
    check_eq("rst_pred_target", 64'(pred_target),      64'h104);
    check_eq("rst_ghr",         64'(ghr_out),          64'd0);
    check_eq("rst_stat",        64'(stat_mispredicts), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    look(32'hFFFF_FFFC);
    check_eq("wrap_target", 64'(pred_target), 64'd0);

    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1);
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0);
    look(32'h100);
    check_eq("two_taken_hit",    64'(pred_btb_hit), 64'd1);
    check_eq("two_taken_pred",   64'(pred_taken),   64'd1);
    check_eq("two_taken_target", 64'(pred_target),  64'h40);
    check_eq("two_taken_ghr",    64'(ghr_out),      64'h03);
    step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    look(32'h100);
    check_eq("after_nt_pred", 64'(pred_taken), 64'd1);

    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0);
    step(32'h100, 1'b1, 32'h200, 1'b1, 32'h80, 1'b0);
    look(32'h100);
    check_eq("alias_miss_hit",  64'(pred_btb_hit), 64'd0);
    check_eq("alias_miss_pred", 64'(pred_taken),   64'd0);
    look(32'h200);
    check_eq("alias_target", 64'(pred_target), 64'h80);

    for (int i = 0; i < 40; i++) step(32'h300, 1'b1, 32'h300, 1'((i % 2) == 1), 32'h3C0, 1'b0);
    look(32'h300);
    check_eq("alt_ghr", 64'(ghr_out), 64'h55);
    check_eq("alt_chooser_model", 64'(m_ch[(32'h300 / 4) % PHT_N]), 64'd3);

    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h44, 1'b0);
    check_eq("same_cycle_old", 64'(pred_btb_hit), 64'd0);
    look(32'h100);
    check_eq("same_cycle_new", 64'(pred_btb_hit), 64'd1);

    @(negedge clk);
    force dut.r_stat = 32'hFFFF_FFFE;
    #1;
    release dut.r_stat;
    m_stat = 32'hFFFF_FFFE;
    step(32'h300, 1'b1, 32'h300, 1'b1, 32'h3C0, 1'b1);
    step(32'h300, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
    step(32'h300, 1'b1, 32'h300, 1'b1, 32'h3C0, 1'b1);
    look(32'h300);
    check_eq("stat_saturated", 64'(stat_mispredicts), 64'hFFFF_FFFF);

    @(negedge clk);
    if (p_valid) model_update(p_pc, p_taken, p_target, p_mis);
    p_valid = 1'b0;
    lookup_pc = 32'h500; upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = 1'b1;
    upd_target = 32'h1234; upd_mispredict = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_pred_taken",  64'(pred_taken),       64'd0);
    check_eq("midrst_btb_hit",     64'(pred_btb_hit),     64'd0);
    check_eq("midrst_pred_target", 64'(pred_target),      64'h504);
    check_eq("midrst_ghr",         64'(ghr_out),          64'd0);
    check_eq("midrst_stat",        64'(stat_mispredicts), 64'd0);
    @(posedge clk);
    #1;
    check_eq("midrst_hold_hit",  64'(pred_btb_hit),     64'd0);
    check_eq("midrst_hold_ghr",  64'(ghr_out),          64'd0);
    check_eq("midrst_hold_stat", 64'(stat_mispredicts), 64'd0);
    @(negedge clk);
    rst = 1'b1; upd_valid = 1'b0;
    model_reset();
    look(32'h500);
    check_eq("post_rst_miss", 64'(pred_btb_hit), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      step(rand_pc(), 1'($urandom_range(0, 3) != 0), rand_pc(), 1'($urandom_range(0, 1)),
           $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
    end
    look(rand_pc());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
